// File: rtl/usb_ep0_setup_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_ep0_setup_rx_pkg
// Shared USB definitions for the endpoint-0 SETUP receive path:
//   - packet identifiers (SETUP, DATA0, DATA1)
//   - CRC16 constants (init, reflected polynomial, good-packet residual)
//   - bit positions of the fields inside a 24-bit token word
//   - SETUP receiver FSM state encoding and byte-count limits
// ---------------------------------------------------------------------------
package usb_ep0_setup_rx_pkg;

   localparam logic [7:0]  PID_SETUP           = 8'h2D;
   localparam logic [7:0]  PID_DATA0           = 8'hC3;
   localparam logic [7:0]  PID_DATA1           = 8'h4B;

   // Reflected (LSB-first) CRC16 register view: 0x8005 becomes 0xA001
   localparam logic [15:0] USB_CRC16_INIT      = 16'hFFFF;
   localparam logic [15:0] USB_CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] USB_CRC16_RESIDUAL  = 16'hB001;

   // Token word layout: [7:0] PID, [14:8] ADDR, [18:15] ENDP, [23:19] CRC5
   localparam int TOK_PID_LSB  = 0;
   localparam int TOK_PID_MSB  = 7;
   localparam int TOK_ADDR_LSB = 8;
   localparam int TOK_ADDR_MSB = 14;
   localparam int TOK_ENDP_LSB = 15;
   localparam int TOK_ENDP_MSB = 18;
   localparam int TOK_CRC5_LSB = 19;
   localparam int TOK_CRC5_MSB = 23;

   // 8 request bytes + 2 CRC bytes; counter sticks one past that
   localparam logic [3:0]  CNT_FULL = 4'd10;
   localparam logic [3:0]  CNT_SAT  = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_DATA = 2'd1,
      ST_RX        = 2'd2
   } state_t;

endpackage

// File: rtl/usb_ep0_setup_rx_crc16.sv
// ---------------------------------------------------------------------------
// usb_ep0_setup_rx_crc16
// Combinational USB CRC16 update, one byte per call, LSB-first bit order,
// held in the reflected register form (poly 0x8005 -> 0xA001). Shared by the
// receive and transmit paths.
// Ports:
//   i_crc  [15:0]  current CRC register
//   i_byte [7:0]   byte to absorb (bit 0 is first on the wire)
//   o_crc  [15:0]  CRC register after absorbing i_byte
// ---------------------------------------------------------------------------
module usb_ep0_setup_rx_crc16
   import usb_ep0_setup_rx_pkg::*;
(
   input  logic [15:0] i_crc,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_crc
);

   logic [15:0] w_acc;

   always_comb begin
      w_acc = i_crc ^ {8'h00, i_byte};
      for (int b = 0; b < 8; b++) begin
         if (w_acc[0]) begin
            w_acc = {1'b0, w_acc[15:1]} ^ USB_CRC16_POLY_REFL;
         end else begin
            w_acc = {1'b0, w_acc[15:1]};
         end
      end
   end

   assign o_crc = w_acc;

endmodule

// File: rtl/usb_ep0_setup_rx.sv
// ---------------------------------------------------------------------------
// usb_ep0_setup_rx
// Endpoint-0 SETUP receiver. Watches the token stream for a SETUP addressed
// to this device/endpoint, captures the following 8-byte DATA0 packet plus
// its CRC16, and on a clean packet publishes the request fields together
// with a one-cycle ACK request. Any rejected attempt raises SETUP_ERR.
// Ports:
//   i_usb_clkin       clock (60 MHz ULPI), single domain
//   i_rst             asynchronous active-high reset
//   i_dev_addr [6:0]  current device address
//   i_token [23:0]    {CRC5, ENDP, ADDR, PID}, valid with i_token_strb
//   i_token_strb      token valid pulse
//   i_data [7:0]      payload byte, valid with i_data_strb
//   i_data_strb       high on each byte cycle
//   i_data_end        pulse after the last byte of a good PHY packet
//   i_data_fail       pulse on PHY packet abort
//   i_pid [7:0]       data-packet PID, valid with i_data_strb
//   o_bm_req_type, o_b_request, o_w_value, o_w_index, o_w_length
//                     decoded request fields, held until the next valid SETUP
//   o_setup_valid     pulse: fields updated
//   o_setup_err       pulse: SETUP attempt rejected
//   o_ack_req         pulse to handshake transmitter, with o_setup_valid
//   o_next_toggle     expected data-stage toggle (1 = DATA1)
//   o_busy            receiver not idle
// ---------------------------------------------------------------------------
module usb_ep0_setup_rx
   import usb_ep0_setup_rx_pkg::*;
#(
   parameter int EP_NUM      = 0,
   parameter int TIMEOUT_CYC = 1024
)(
   input  logic        i_usb_clkin,
   input  logic        i_rst,
   input  logic [6:0]  i_dev_addr,
   input  logic [23:0] i_token,
   input  logic        i_token_strb,
   input  logic [7:0]  i_data,
   input  logic        i_data_strb,
   input  logic        i_data_end,
   input  logic        i_data_fail,
   input  logic [7:0]  i_pid,
   output logic [7:0]  o_bm_req_type,
   output logic [7:0]  o_b_request,
   output logic [15:0] o_w_value,
   output logic [15:0] o_w_index,
   output logic [15:0] o_w_length,
   output logic        o_setup_valid,
   output logic        o_setup_err,
   output logic        o_ack_req,
   output logic        o_next_toggle,
   output logic        o_busy
);

   localparam int               TMR_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
   localparam logic [3:0]       EP_ID   = 4'(EP_NUM);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == CNT_SAT) ? v : v + 4'd1;
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TMR_W-1:0]  r_timer;
   logic [3:0]        r_cnt;
   logic [15:0]       r_crc;
   logic [15:0]       w_crc_nxt;
   logic [7:0]        r_buf [0:9];

   logic              w_tok_setup;
   logic              w_crc_ok;
   logic              w_restart;
   logic              w_first;
   logic              w_store;
   logic              w_tick;
   logic              w_evt_valid;
   logic              w_evt_err;

   logic [7:0]        r_bm_req_type;
   logic [7:0]        r_b_request;
   logic [15:0]       r_w_value;
   logic [15:0]       r_w_index;
   logic [15:0]       r_w_length;
   logic              r_setup_valid;
   logic              r_setup_err;
   logic              r_ack_req;
   logic              r_next_toggle;

   // Token CRC5 is already checked upstream
   logic              w_unused_tok_crc5;
   assign w_unused_tok_crc5 = ^i_token[TOK_CRC5_MSB:TOK_CRC5_LSB];

   assign w_tok_setup = i_token_strb
                      && (i_token[TOK_PID_MSB:TOK_PID_LSB]   == PID_SETUP)
                      && (i_token[TOK_ADDR_MSB:TOK_ADDR_LSB] == i_dev_addr)
                      && (i_token[TOK_ENDP_MSB:TOK_ENDP_LSB] == EP_ID);

   assign w_crc_ok = (r_crc == USB_CRC16_RESIDUAL);

   usb_ep0_setup_rx_crc16 u_crc (
      .i_crc  (r_crc),
      .i_byte (i_data),
      .o_crc  (w_crc_nxt)
   );

   // FSM state register
   always_ff @(posedge i_usb_clkin or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: token > fail > end/data > timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_tok_setup) w_state_nxt = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            if (i_token_strb) begin
               w_state_nxt = w_tok_setup ? ST_WAIT_DATA : ST_IDLE;
            end else if (i_data_fail) begin
               w_state_nxt = ST_IDLE;
            end else if (i_data_strb) begin
               w_state_nxt = (i_pid == PID_DATA0) ? ST_RX : ST_IDLE;
            end else if (r_timer == TMR_MAX) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RX: begin
            if (i_token_strb) begin
               w_state_nxt = w_tok_setup ? ST_WAIT_DATA : ST_IDLE;
            end else if (i_data_fail || i_data_end) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes and pulse events, same priority as above
   always_comb begin
      w_restart   = 1'b0;
      w_first     = 1'b0;
      w_store     = 1'b0;
      w_tick      = 1'b0;
      w_evt_valid = 1'b0;
      w_evt_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_restart = w_tok_setup;
         end
         ST_WAIT_DATA: begin
            if (i_token_strb) begin
               w_evt_err = 1'b1;
               w_restart = w_tok_setup;
            end else if (i_data_fail) begin
               w_evt_err = 1'b1;
            end else if (i_data_strb) begin
               if (i_pid == PID_DATA0) w_first   = 1'b1;
               else                    w_evt_err = 1'b1;
            end else if (r_timer == TMR_MAX) begin
               w_evt_err = 1'b1;
            end else begin
               w_tick = 1'b1;
            end
         end
         ST_RX: begin
            if (i_token_strb) begin
               w_evt_err = 1'b1;
               w_restart = w_tok_setup;
            end else if (i_data_fail) begin
               w_evt_err = 1'b1;
            end else if (i_data_end) begin
               if ((r_cnt == CNT_FULL) && w_crc_ok) w_evt_valid = 1'b1;
               else                                 w_evt_err   = 1'b1;
            end else if (i_data_strb) begin
               w_store = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Timer, byte counter and running CRC
   always_ff @(posedge i_usb_clkin or posedge i_rst) begin
      if (i_rst) begin
         r_timer <= '0;
         r_cnt   <= 4'd0;
         r_crc   <= USB_CRC16_INIT;
      end else if (w_restart) begin
         r_timer <= '0;
         r_cnt   <= 4'd0;
         r_crc   <= USB_CRC16_INIT;
      end else if (w_first || w_store) begin
         r_cnt   <= sat_inc(r_cnt);
         r_crc   <= w_crc_nxt;
      end else if (w_tick) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Capture buffer; bytes beyond the CRC position only feed the CRC/count
   always_ff @(posedge i_usb_clkin) begin
      if ((w_first || w_store) && (r_cnt < CNT_FULL)) begin
         r_buf[r_cnt] <= i_data;
      end
   end

   // Output registers: pulses land one cycle after the deciding edge
   always_ff @(posedge i_usb_clkin or posedge i_rst) begin
      if (i_rst) begin
         r_bm_req_type <= 8'h00;
         r_b_request   <= 8'h00;
         r_w_value     <= 16'h0000;
         r_w_index     <= 16'h0000;
         r_w_length    <= 16'h0000;
         r_setup_valid <= 1'b0;
         r_setup_err   <= 1'b0;
         r_ack_req     <= 1'b0;
         r_next_toggle <= 1'b0;
      end else begin
         r_setup_valid <= w_evt_valid;
         r_ack_req     <= w_evt_valid;
         r_setup_err   <= w_evt_err;
         if (w_evt_valid) begin
            r_bm_req_type <= r_buf[0];
            r_b_request   <= r_buf[1];
            r_w_value     <= {r_buf[3], r_buf[2]};
            r_w_index     <= {r_buf[5], r_buf[4]};
            r_w_length    <= {r_buf[7], r_buf[6]};
            r_next_toggle <= 1'b1;
         end
      end
   end

   assign o_bm_req_type = r_bm_req_type;
   assign o_b_request   = r_b_request;
   assign o_w_value     = r_w_value;
   assign o_w_index     = r_w_index;
   assign o_w_length    = r_w_length;
   assign o_setup_valid = r_setup_valid;
   assign o_setup_err   = r_setup_err;
   assign o_ack_req     = r_ack_req;
   assign o_next_toggle = r_next_toggle;
   assign o_busy        = (r_state != ST_IDLE);

endmodule
